// File: rtl/sensor_sequencer.sv
// sensor_sequencer
//   Frame sequencer for a rolling pixel array: ERASE -> EXPOSE -> CONVERT -> READ,
//   then either back to IDLE or, with continuous high, straight into the next ERASE.
//   Every output is a flop; p_convert stands in for a gated analog-ramp clock.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         request one frame (only looked at in IDLE)
//   continuous    at frame end, chain directly into the next frame
//   abort         synchronous return to IDLE, beats start and continuous
//   expose_time   exposure length in cycles (0 behaves as 1), latched at frame start
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse on the last READ cycle
//   p_erase/p_expose/p_convert  one-hot phase enables
//   p_dRamp       digital ramp, counts 0..all-ones during CONVERT, 0 elsewhere
//   p_row_select  one-hot row select during READ, 0 elsewhere
//   phase         IDLE=0 ERASE=1 EXPOSE=2 CONVERT=3 READ=4
module sensor_sequencer #(
  parameter int ROWS            = 2,
  parameter int RAMP_BITS       = 8,
  parameter int ERASE_CYCLES    = 5,
  parameter int ROW_READ_CYCLES = 5,
  parameter int EXP_BITS        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [EXP_BITS-1:0]  expose_time,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 p_erase,
  output logic                 p_expose,
  output logic                 p_convert,
  output logic [RAMP_BITS-1:0] p_dRamp,
  output logic [ROWS-1:0]      p_row_select,
  output logic [2:0]           phase
);

  localparam int CONV_CYCLES = 1 << RAMP_BITS;
  localparam int READ_CYCLES = ROWS * ROW_READ_CYCLES;
  localparam int EXP_MAX     = 1 << EXP_BITS;
  localparam int MAX_AB      = (ERASE_CYCLES > EXP_MAX) ? ERASE_CYCLES : EXP_MAX;
  localparam int MAX_CD      = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
  localparam int CNT_MAX     = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int SUB_W       = $clog2(ROW_READ_CYCLES + 1);

  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(ROW_READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [EXP_BITS-1:0]  exp_q, exp_d;
  logic [ROWS-1:0]      row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 erase_q, erase_d;
  logic                 expose_q, expose_d;
  logic                 convert_q, convert_d;
  logic [RAMP_BITS-1:0] ramp_q, ramp_d;

  logic [EXP_BITS-1:0]  exp_eff;
  logic [CNT_W-1:0]     exp_last;

  // A zero exposure request is stretched to one cycle.
  assign exp_eff  = (expose_time == '0) ? EXP_BITS'(1) : expose_time;
  assign exp_last = CNT_W'(exp_q) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    sub_d   = sub_q;
    exp_d   = exp_q;
    row_d   = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_ERASE;
          exp_d   = exp_eff;
        end
      end
      S_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == exp_last) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end
      end
      S_CONVERT: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
          sub_d   = '0;
          row_d   = ROWS'(1);
        end
      end
      S_READ: begin
        // sub_q counts cycles within the current row; the one-hot select
        // walks upward each time it wraps.
        row_d = row_q;
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          row_d = row_q << 1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
        if (cnt_q == READ_LAST) begin
          cnt_d = '0;
          sub_d = '0;
          row_d = '0;
          if (continuous) begin
            state_d = S_ERASE;
            exp_d   = exp_eff;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sub_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sub_d   = '0;
      row_d   = '0;
    end

    // Outputs are decoded from the next state so they line up with phase.
    busy_d       = (state_d != S_IDLE);
    erase_d      = (state_d == S_ERASE);
    expose_d     = (state_d == S_EXPOSE);
    convert_d    = (state_d == S_CONVERT);
    ramp_d       = (state_d == S_CONVERT) ? cnt_d[RAMP_BITS-1:0] : '0;
    frame_done_d = (state_d == S_READ) && (cnt_d == READ_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sub_q        <= '0;
      exp_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      ramp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      exp_q        <= exp_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      ramp_q       <= ramp_d;
    end
  end

  assign phase        = state_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign p_erase      = erase_q;
  assign p_expose     = expose_q;
  assign p_convert    = convert_q;
  assign p_dRamp      = ramp_q;
  assign p_row_select = row_q;

endmodule

// File: tb/tb_sensor_sequencer.sv
// Testbench for sensor_sequencer: a default-parameter instance and a
// ROWS=4 / RAMP_BITS=4 instance share one stimulus stream; each is compared
// every cycle against a frame-timeline model (phase derived from the offset
// into the frame), plus directed checks on frame timing and corner cases.
module tb_sensor_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, continuous, abort;
  logic [7:0] expose_time;

  logic       d1_busy, d1_fd, d1_pe, d1_px, d1_pc;
  logic [7:0] d1_ramp;
  logic [1:0] d1_rs;
  logic [2:0] d1_phase;

  logic       d2_busy, d2_fd, d2_pe, d2_px, d2_pc;
  logic [3:0] d2_ramp;
  logic [3:0] d2_rs;
  logic [2:0] d2_phase;

  sensor_sequencer u_dut1 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .expose_time(expose_time), .busy(d1_busy),
    .frame_done(d1_fd), .p_erase(d1_pe), .p_expose(d1_px),
    .p_convert(d1_pc), .p_dRamp(d1_ramp), .p_row_select(d1_rs),
    .phase(d1_phase)
  );

  sensor_sequencer #(.ROWS(4), .RAMP_BITS(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .expose_time(expose_time), .busy(d2_busy),
    .frame_done(d2_fd), .p_erase(d2_pe), .p_expose(d2_px),
    .p_convert(d2_pc), .p_dRamp(d2_ramp), .p_row_select(d2_rs),
    .phase(d2_phase)
  );

  logic [31:0] a1, a2;
  assign a1 = {d1_phase, d1_busy, d1_fd, d1_pe, d1_px, d1_pc, 16'(d1_ramp), 8'(d1_rs)};
  assign a2 = {d2_phase, d2_busy, d2_fd, d2_pe, d2_px, d2_pc, 16'(d2_ramp), 8'(d2_rs)};

  int checks = 0;
  int failures = 0;

  bit m1_act = 0, m2_act = 0;
  int m1_off = 0, m2_off = 0, m1_e = 1, m2_e = 1;

  // Expected packed outputs for a frame that is 'off' cycles in, exposure e.
  function automatic logic [31:0] expect_vec(input bit act, input int off, input int e,
                                             input int rows, input int rb,
                                             input int er, input int rrc);
    logic [2:0]  ph;
    logic        bz, fd, pe, px, pc;
    logic [15:0] ramp;
    logic [7:0]  rs;
    int conv, r;
    ph = '0; bz = 0; fd = 0; pe = 0; px = 0; pc = 0; ramp = '0; rs = '0;
    conv = 1 << rb;
    if (act) begin
      bz = 1;
      if (off < er) begin
        ph = 3'd1; pe = 1;
      end else if (off < er + e) begin
        ph = 3'd2; px = 1;
      end else if (off < er + e + conv) begin
        ph = 3'd3; pc = 1; ramp = 16'(off - er - e);
      end else begin
        r  = off - er - e - conv;
        ph = 3'd4;
        rs = 8'(1 << (r / rrc));
        fd = (r == rows * rrc - 1);
      end
    end
    return {ph, bz, fd, pe, px, pc, ramp, rs};
  endfunction

  task automatic model_edge(input int rows, input int rb, input int er, input int rrc,
                            inout bit act, inout int off, inout int e);
    int total;
    if (!act) begin
      if (start && !abort) begin
        act = 1; off = 0;
        e = (expose_time == 0) ? 1 : int'(expose_time);
      end
    end else if (abort) begin
      act = 0;
    end else begin
      total = er + e + (1 << rb) + rows * rrc;
      if (off == total - 1) begin
        if (continuous) begin
          off = 0;
          e = (expose_time == 0) ? 1 : int'(expose_time);
        end else begin
          act = 0;
        end
      end else begin
        off++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      m1_act = 0; m2_act = 0;
    end else begin
      model_edge(2, 8, 5, 5, m1_act, m1_off, m1_e);
      model_edge(4, 4, 5, 5, m2_act, m2_off, m2_e);
    end
    #1;
    chk("cyc_dut1", a1, expect_vec(m1_act, m1_off, m1_e, 2, 8, 5, 5));
    chk("cyc_dut2", a2, expect_vec(m2_act, m2_off, m2_e, 4, 4, 5, 5));
  endtask

  int n, g, c2conv, c2read, drops, nexp, nfd;

  initial begin
    reset = 1'b1; start = 0; continuous = 0; abort = 0; expose_time = 8'd0;
    #2 reset = 1'b0;
    #2;
    chk("rst_dut1", a1, 32'd0);
    chk("rst_dut2", a2, 32'd0);
    step(); step();
    #2 reset = 1'b1;

    // Reference frame, expose_time=10.
    expose_time = 8'd10; start = 1; n = 0; c2conv = 0; c2read = 0;
    do begin
      step(); start = 0; n++;
      if (d2_pc) c2conv++;
      if (d2_rs != 0) c2read++;
      if (n == 1)   chk("a_erase_first", 32'(d1_phase), 32'd1);
      if (n == 6)   chk("a_expose_first", 32'(d1_phase), 32'd2);
      if (n == 16)  chk("a_ramp_first", {d1_phase, 21'd0, d1_ramp}, {3'd3, 21'd0, 8'd0});
      if (n == 271) chk("a_ramp_last", {d1_phase, 21'd0, d1_ramp}, {3'd3, 21'd0, 8'd255});
      if (n == 272) chk("a_row0_first", 32'(d1_rs), 32'd1);
      if (n == 277) chk("a_row1_first", 32'(d1_rs), 32'd2);
    end while (d1_fd !== 1'b1 && n < 400);
    chk("a_fd_edge", 32'(n), 32'd281);
    step();
    chk("a_idle_after", a1, 32'd0);
    chk("p2_convert_len", 32'(c2conv), 32'd16);
    chk("p2_read_len", 32'(c2read), 32'd20);

    // Zero exposure: frame is 272 busy cycles.
    expose_time = 8'd0; start = 1; n = 0; g = 0;
    do begin
      step(); start = 0; g++;
      if (d1_busy) n++;
    end while (d1_busy && g < 400);
    chk("b_frame_len", 32'(n), 32'd272);

    // Continuous with an exposure change mid-frame.
    expose_time = 8'd10; continuous = 1; start = 1; g = 0; drops = 0;
    do begin
      step(); start = 0; g++;
      if (g == 20) expose_time = 8'd3;
      if (!d1_busy) drops++;
    end while (d1_fd !== 1'b1 && g < 400);
    chk("c_frame1_len", 32'(g), 32'd281);
    step();
    chk("c_erase_next", 32'(d1_phase), 32'd1);
    continuous = 0; nexp = 0; g = 0;
    do begin
      step(); g++;
      if (d1_px) nexp++;
      if (!d1_busy) drops++;
    end while (d1_fd !== 1'b1 && g < 400);
    chk("c_expose2_len", 32'(nexp), 32'd3);
    chk("c_busy_drops", 32'(drops), 32'd0);
    g = 0;
    do begin step(); g++; end while ((d1_busy || d2_busy) && g < 400);
    chk("c_idle_timeout", 32'(g < 400), 32'd1);

    // Start pulsed during CONVERT is ignored.
    expose_time = 8'd4; start = 1; g = 0; nfd = 0;
    do begin
      step(); start = 0; g++;
      if (g == 50) start = 1;
      if (d1_fd) nfd++;
    end while (g < 300);
    chk("d_one_frame", 32'(nfd), 32'd1);
    chk("d_idle", 32'(d1_busy), 32'd0);

    // Abort at ramp value 100, then a clean frame.
    expose_time = 8'd10; start = 1; g = 0;
    do begin step(); start = 0; g++; end
      while (!(d1_pc && d1_ramp == 8'd100) && g < 400);
    chk("e_reach_ramp100", 32'(d1_ramp), 32'd100);
    abort = 1; step(); abort = 0;
    chk("e_abort_zero", a1, 32'd0);
    start = 1; n = 0; g = 0;
    do begin
      step(); start = 0; g++;
      if (d1_busy) n++;
    end while (d1_busy && g < 400);
    chk("e_full_frame", 32'(n), 32'd281);

    // Abort on the last READ cycle suppresses chaining and frame_done.
    g = 0;
    do begin step(); g++; end while (d2_busy && g < 100);
    continuous = 1; start = 1; g = 0;
    do begin step(); start = 0; g++; end while (d1_fd !== 1'b1 && g < 400);
    abort = 1; step(); abort = 0; continuous = 0;
    chk("h_abort_last_read", a1, 32'd0);
    g = 0;
    do begin step(); g++; end while ((d1_busy || d2_busy) && g < 400);

    // Asynchronous reset during READ.
    start = 1; g = 0;
    do begin step(); start = 0; g++; end while (d1_rs == 2'b00 && g < 400);
    #3 reset = 1'b0;
    #1;
    chk("f_async_dut1", a1, 32'd0);
    chk("f_async_dut2", a2, 32'd0);
    m1_act = 0; m2_act = 0;
    #2 reset = 1'b1;
    start = 1;
    step(); start = 0;
    chk("f_start_after_release", 32'(d1_phase), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      abort      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) continuous = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0) expose_time = 8'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_sequencer.md
SENSOR_SEQUENCER -- requirements
Module: sensor_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 2, meaning pixel-array row count (>=1).
REQ-002 SHALL have parameter RAMP_BITS, default 8, meaning width of the digital ramp; the convert phase lasts 2^RAMP_BITS cycles.
REQ-003 SHALL have parameter ERASE_CYCLES, default 5, meaning erase phase length in cycles (>=1).
REQ-004 SHALL have parameter ROW_READ_CYCLES, default 5, meaning cycles each row stays selected (>=1).
REQ-005 SHALL have parameter EXP_BITS, default 8, meaning width of the exposure-time input.
REQ-006 SHALL have one clock and one reset: port clk is the single clock; port reset is asynchronous and active-low.
REQ-007 SHALL have ports: clk  in  1  clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request one frame; sampled only in IDLE.
REQ-010 continuous  in  1  when high at frame end, the next frame starts with no IDLE gap.
REQ-011 abort  in  1  synchronous stop to IDLE.
REQ-012 expose_time  in  EXP_BITS  exposure length in cycles; 0 is treated as 1.
REQ-013 busy  out  1  high in every non-IDLE state.
REQ-014 frame_done  out  1  one-cycle pulse on the last READ cycle.
REQ-015 p_erase, p_expose, p_convert  out  1 each  phase enables, one-hot with each other.
REQ-016 p_dRamp  out  RAMP_BITS  digital ramp value.
REQ-017 p_row_select  out  ROWS  one-hot row select; all zero outside READ.
REQ-018 phase  out  3  encoding: IDLE=0, ERASE=1, EXPOSE=2, CONVERT=3, READ=4.

Function
REQ-019 SHALL register all outputs; there is no clock gating and no X/Z drive (p_convert replaces the gated analog-ramp clock).
REQ-020 IDLE: start=1 and abort=0 at edge N -> ERASE from edge N+1; expose_time is latched at that same edge N.
REQ-021 ERASE SHALL last exactly ERASE_CYCLES cycles with p_erase=1, then go to EXPOSE.
REQ-022 EXPOSE SHALL last max(latched expose_time,1) cycles with p_expose=1, then go to CONVERT.
REQ-023 CONVERT SHALL last 2^RAMP_BITS cycles with p_convert=1; p_dRamp is 0 in the first cycle, increments by 1 per cycle, and reaches all-ones in the last cycle with no wrap.
REQ-024 p_dRamp SHALL be 0 in every state other than CONVERT.
REQ-025 READ SHALL last ROWS*ROW_READ_CYCLES cycles.
REQ-026 In READ, p_row_select bit k SHALL be high during cycles k*ROW_READ_CYCLES to (k+1)*ROW_READ_CYCLES-1 (bit 0 first).
REQ-027 At the last READ cycle, frame_done=1.
REQ-028 At the end of READ, continuous=1 -> ERASE next cycle with expose_time re-latched; continuous=0 -> IDLE.
REQ-029 start SHALL be ignored while busy=1; no queuing.
REQ-030 abort=1 at any edge -> IDLE next cycle with all outputs 0 and no frame_done, including on the last READ cycle.
REQ-031 abort SHALL take priority over start and over continuous.
REQ-032 Changes to expose_time mid-frame SHALL NOT affect the current frame.
REQ-033 Internal phase counters SHALL be sized for the largest of ERASE_CYCLES, 2^EXP_BITS, 2^RAMP_BITS and ROWS*ROW_READ_CYCLES.
REQ-034 Any undefined phase encoding SHALL recover to IDLE next cycle.

Reset
REQ-035 reset=0 SHALL immediately, without clk, force phase=IDLE, busy=0, frame_done=0, p_erase=p_expose=p_convert=0, p_dRamp=0, p_row_select=0, and clear all counters.
REQ-036 Reset asserted mid-frame SHALL discard the frame; after release, no activity SHALL occur until a new start.
REQ-037 The first edge after reset release SHALL already be able to accept start.

Verification
REQ-038 Defaults, expose_time=10, start pulse at edge 0 -> ERASE at edges 1-5, EXPOSE 6-15, CONVERT 16-271 (p_dRamp 0..255), READ 272-281 (row0 272-276, row1 277-281), frame_done at 281, IDLE at 282.
REQ-039 expose_time=0 -> EXPOSE lasts exactly 1 cycle; total frame is 272 cycles.
REQ-040 continuous=1 held, expose_time changed to 3 mid-frame -> second frame ERASE starts the cycle after frame_done, its EXPOSE lasts 3 cycles, and busy never drops.
REQ-041 start pulsed during CONVERT -> no effect; exactly one frame_done.
REQ-042 abort at CONVERT cycle with p_dRamp=100 -> next cycle all outputs 0 and IDLE; a later start produces a full normal frame.
REQ-043 reset low between clock edges during READ -> outputs 0 immediately; parameterised run with ROWS=4, RAMP_BITS=4 gives CONVERT=16 cycles and 4 rows x 5 cycles.
